spi_aes_host: RTL

Host-side SPI controller that drives the AES SPI peripheral from the system clock domain. It accepts a 128-bit block and a mode over a valid/ready request interface. It then shifts the block out on MOSI, pulses START, waits out BUSY, shifts the result back in on MISO, and returns it on a response interface. It generates SCK and keeps it running through the AES operation, because the peripheral's AES core is clocked by SCK.

---
 rtl/spi_aes_pkg.sv | 20 ++
 rtl/spi_sck_gen.sv | 34 +++
 rtl/spi_aes_host.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/spi_aes_pkg.sv
// rtl/spi_aes_pkg.sv - shared types and constants for the AES SPI host
package spi_aes_pkg;

    localparam int BLOCK_W    = 128;
    localparam int GAP_SCK    = 2;
    localparam int SETTLE_SCK = 2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GAP,
        ST_STRT,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_SETTLE,
        ST_READ,
        ST_DONE
    } state_t;

endpackage

// File: rtl/spi_sck_gen.sv
// rtl/spi_sck_gen.sv - SCK divider with edge strobes one CLK ahead of each SCK transition
module spi_sck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sck,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int DIV_W = $clog2(CLK_DIV);

    logic [DIV_W-1:0] div_cnt;
    logic             edge_tick;

    assign edge_tick = en && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign rise_tick = edge_tick && !sck;
    assign fall_tick = edge_tick && sck;

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else if (edge_tick) begin
            div_cnt <= '0;
            sck     <= ~sck;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_aes_host.sv
// rtl/spi_aes_host.sv - host-side SPI controller driving the AES SPI peripheral
module spi_aes_host
    import spi_aes_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int MISO_LAT      = 1,
    parameter int BUSY_RISE_MAX = 16,
    parameter int BUSY_TIMEOUT  = 4096
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [BLOCK_W-1:0] req_data,
    input  logic               req_encrypt,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [BLOCK_W-1:0] rsp_data,
    output logic               rsp_error,
    output logic               SCK,
    output logic               MOSI,
    input  logic               MISO,
    output logic               NORM_CS_N,
    output logic               START,
    output logic               ENCRYPT_NDECRYPT,
    input  logic               BUSY
);

    localparam int WAIT_W     = $clog2(BUSY_TIMEOUT + 1);
    localparam int READ_EDGES = BLOCK_W + MISO_LAT;

    state_t             state, state_n;
    logic               sck_en, rise_tick, fall_tick, accept;
    logic               busy_meta, busy_sync;
    logic [7:0]         bit_cnt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [BLOCK_W-1:0] shift;

    assign accept = req_valid && req_ready;
    // The peripheral's AES core runs off SCK, so SCK keeps toggling through the waits.
    assign sck_en = (state != ST_IDLE) && (state != ST_DONE);

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk       (CLK),
        .rst_n     (RST_N),
        .en        (sck_en),
        .sck       (SCK),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:    if (accept) state_n = ST_LOAD;
            ST_LOAD:    if (fall_tick && !NORM_CS_N && bit_cnt == 8'(BLOCK_W)) state_n = ST_GAP;
            ST_GAP:     if (fall_tick && bit_cnt == 8'(GAP_SCK - 1)) state_n = ST_STRT;
            ST_STRT:    if (fall_tick) state_n = ST_WAIT_HI;
            ST_WAIT_HI: begin
                if (rise_tick && busy_sync) state_n = ST_WAIT_LO;
                else if (rise_tick && wait_cnt == WAIT_W'(BUSY_RISE_MAX - 1)) state_n = ST_DONE;
            end
            ST_WAIT_LO: begin
                if (rise_tick && !busy_sync) state_n = ST_SETTLE;
                else if (rise_tick && wait_cnt == WAIT_W'(BUSY_TIMEOUT - 1)) state_n = ST_DONE;
            end
            ST_SETTLE:  if (fall_tick && bit_cnt == 8'(SETTLE_SCK)) state_n = ST_READ;
            ST_READ:    if (fall_tick && bit_cnt == 8'(READ_EDGES)) state_n = ST_DONE;
            ST_DONE:    if (rsp_valid && rsp_ready) state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state            <= ST_IDLE;
            bit_cnt          <= '0;
            wait_cnt         <= '0;
            shift            <= '0;
            busy_meta        <= 1'b0;
            busy_sync        <= 1'b0;
            MOSI             <= 1'b0;
            NORM_CS_N        <= 1'b1;
            START            <= 1'b0;
            ENCRYPT_NDECRYPT <= 1'b1;
            req_ready        <= 1'b0;
            rsp_valid        <= 1'b0;
            rsp_data         <= '0;
            rsp_error        <= 1'b0;
        end else begin
            state     <= state_n;
            busy_meta <= BUSY;
            busy_sync <= busy_meta;

            if (state_n != state) begin
                bit_cnt  <= '0;
                wait_cnt <= '0;
            end else begin
                if (rise_tick && ((state == ST_LOAD && !NORM_CS_N) || state == ST_READ))
                    bit_cnt <= bit_cnt + 8'd1;
                if (fall_tick && (state == ST_GAP || state == ST_SETTLE))
                    bit_cnt <= bit_cnt + 8'd1;
                if (rise_tick && (state == ST_WAIT_HI || state == ST_WAIT_LO))
                    wait_cnt <= wait_cnt + WAIT_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    req_ready <= !accept;
                    if (accept) begin
                        shift            <= req_data;
                        ENCRYPT_NDECRYPT <= req_encrypt;
                    end
                end
                ST_LOAD: begin
                    // The first fall drops CS and presents the MSB ahead of the first counted rise.
                    if (fall_tick && state_n == ST_GAP) begin
                        NORM_CS_N <= 1'b1;
                        MOSI      <= 1'b0;
                    end else if (fall_tick) begin
                        NORM_CS_N <= 1'b0;
                        MOSI      <= shift[BLOCK_W-1];
                        shift     <= {shift[BLOCK_W-2:0], 1'b0};
                    end
                end
                ST_GAP:  if (state_n == ST_STRT) START <= 1'b1;
                ST_STRT: if (fall_tick) START <= 1'b0;
                ST_WAIT_HI, ST_WAIT_LO: begin
                    if (state_n == ST_DONE) begin
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b1;
                        rsp_data  <= '0;
                    end
                end
                ST_SETTLE: if (state_n == ST_READ) NORM_CS_N <= 1'b0;
                ST_READ: begin
                    if (rise_tick && bit_cnt >= 8'(MISO_LAT))
                        shift <= {shift[BLOCK_W-2:0], MISO};
                    if (state_n == ST_DONE) begin
                        NORM_CS_N <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b0;
                        rsp_data  <= shift;
                    end
                end
                ST_DONE: begin
                    if (state_n == ST_IDLE) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
